// File: rtl/thread_state_mc_pkg.sv
// thread_state_mc_pkg: thread state width, scanner state encoding and width helper
package thread_state_mc_pkg;
    localparam int THREAD_STATE_MSB = 1;
    typedef enum logic [1:0] {SC_IDLE, SC_SCAN, SC_DONE} scan_state_e;
    function automatic int msb(input int v);
        return v < 2 ? 0 : $clog2(v + 1) - 1;
    endfunction
endpackage

// File: rtl/thread_state_mc_if.sv
// thread_state_mc_if: write/read channels, scan request/result and error flag of the thread state table
// master drives wr_*, rd_num, scan_req/match/claim; slave (the table) drives rd_state, scan_busy/done/hit/num, err
interface thread_state_mc_if import thread_state_mc_pkg::*; #(
    parameter int N_THREADS   = 16,
    parameter int N_CHANNELS  = 4,
    parameter int STATE_WIDTH = THREAD_STATE_MSB + 1
);
    localparam int NW = msb(N_THREADS - 1) + 1;
    logic [N_CHANNELS-1:0]             wr_en;
    logic [N_CHANNELS*NW-1:0]          wr_num;
    logic [N_CHANNELS*STATE_WIDTH-1:0] wr_state;
    logic [N_CHANNELS*NW-1:0]          rd_num;
    logic [N_CHANNELS*STATE_WIDTH-1:0] rd_state;
    logic                              scan_req;
    logic [STATE_WIDTH-1:0]            scan_match;
    logic [STATE_WIDTH-1:0]            scan_claim;
    logic                              scan_busy;
    logic                              scan_done;
    logic                              scan_hit;
    logic [NW-1:0]                     scan_num;
    logic                              err;
    modport master (
        output wr_en, wr_num, wr_state, rd_num, scan_req, scan_match, scan_claim,
        input  rd_state, scan_busy, scan_done, scan_hit, scan_num, err
    );
    modport slave (
        input  wr_en, wr_num, wr_state, rd_num, scan_req, scan_match, scan_claim,
        output rd_state, scan_busy, scan_done, scan_hit, scan_num, err
    );
endinterface

// File: rtl/thread_state_mc_scan.sv
// ts_scan: round-robin find-and-claim scanner over the thread state table
// in: flattened table, per-thread channel-write mask, req/match/claim; out: busy/done/hit/num and a claim write
module ts_scan import thread_state_mc_pkg::*; #(
    parameter int N_THREADS   = 16,
    parameter int NW          = 4,
    parameter int STATE_WIDTH = 2,
    parameter int SCAN_WIDTH  = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [N_THREADS*STATE_WIDTH-1:0] tbl_flat,
    input  logic [N_THREADS-1:0]             ch_wr,
    input  logic                             req,
    input  logic [STATE_WIDTH-1:0]           match,
    input  logic [STATE_WIDTH-1:0]           claim,
    output logic                             busy,
    output logic                             done,
    output logic                             hit,
    output logic [NW-1:0]                    num,
    output logic                             cl_en,
    output logic [NW-1:0]                    cl_num,
    output logic [STATE_WIDTH-1:0]           cl_state
);
    localparam int NG = N_THREADS / SCAN_WIDTH;
    scan_state_e state, nxt;
    logic [NW-1:0] grp, grp_nx, cnt, base, f_num;
    logic [STATE_WIDTH-1:0] m_q, c_q;
    logic f_hit, last;
    assign base     = grp * NW'(SCAN_WIDTH);
    assign grp_nx   = grp == NW'(NG - 1) ? '0 : grp + 1'b1;
    assign last     = cnt == NW'(NG - 1);
    assign busy     = state == SC_SCAN;
    assign done     = state == SC_DONE;
    assign cl_en    = busy && f_hit;
    assign cl_num   = f_num;
    assign cl_state = c_q;
    // descending walk so the lowest qualifying index is the one left standing
    always_comb begin
        f_hit = 1'b0;
        f_num = '0;
        for (int i = SCAN_WIDTH - 1; i >= 0; i--)
            if (tbl_flat[(base + NW'(i)) * STATE_WIDTH +: STATE_WIDTH] == m_q && !ch_wr[base + NW'(i)]) begin
                f_hit = 1'b1;
                f_num = base + NW'(i);
            end
    end
    always_comb begin
        nxt = state == SC_IDLE ? (req ? SC_SCAN : SC_IDLE)
            : state == SC_SCAN ? (f_hit || last ? SC_DONE : SC_SCAN)
            : SC_IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= SC_IDLE;
        else     state <= nxt;
    end
    // grp always advances: after a hit it points past the hit group, after a full miss it is back at its start
    always_ff @(posedge CLK) begin
        if (RST) begin
            grp <= '0;
            cnt <= '0;
            m_q <= '0;
            c_q <= '0;
            hit <= 1'b0;
            num <= '0;
        end else if (state == SC_IDLE && req) begin
            m_q <= match;
            c_q <= claim;
            cnt <= '0;
        end else if (busy) begin
            grp <= grp_nx;
            cnt <= cnt + 1'b1;
            if (f_hit || last) hit <= f_hit;
            if (f_hit) num <= f_num;
        end
    end
endmodule

// File: rtl/thread_state_mc.sv
// thread_state_mc: multi-channel thread state table with fixed-priority writes, registered reads and a claim scanner
// CLK/RST plain ports; bus (slave modport) carries write/read channels, scan request/result and sticky err
module thread_state_mc import thread_state_mc_pkg::*; #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1),
    parameter int N_CHANNELS    = 4,
    parameter int STATE_WIDTH   = THREAD_STATE_MSB + 1,
    parameter logic [STATE_WIDTH-1:0] RESET_STATE = '0,
    parameter int SCAN_WIDTH    = 4
) (
    input logic CLK,
    input logic RST,
    thread_state_mc_if.slave bus
);
    localparam int NW = N_THREADS_MSB + 1;
    logic [STATE_WIDTH-1:0] tbl [N_THREADS];
    logic [N_THREADS*STATE_WIDTH-1:0] tbl_flat;
    logic [N_CHANNELS*STATE_WIDTH-1:0] rd_q;
    logic [N_THREADS-1:0] ch_wr;
    logic [NW-1:0] cl_num;
    logic [STATE_WIDTH-1:0] cl_state;
    logic coll, cl_en, err_q;
    for (genvar j = 0; j < N_THREADS; j++) begin : g_flat
        assign tbl_flat[j*STATE_WIDTH +: STATE_WIDTH] = tbl[j];
    end
    assign bus.rd_state = rd_q;
    assign bus.err      = err_q;
    always_comb begin
        ch_wr = '0;
        coll  = 1'b0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (bus.wr_en[c]) ch_wr[bus.wr_num[c*NW +: NW]] = 1'b1;
            for (int k = c + 1; k < N_CHANNELS; k++)
                coll |= bus.wr_en[c] && bus.wr_en[k] && bus.wr_num[c*NW +: NW] == bus.wr_num[k*NW +: NW];
        end
    end
    // writes issued lowest priority first: the last nonblocking assignment to an entry wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < N_THREADS; j++) tbl[j] <= RESET_STATE;
            rd_q  <= {N_CHANNELS{RESET_STATE}};
            err_q <= 1'b0;
        end else begin
            if (cl_en) tbl[cl_num] <= cl_state;
            for (int c = N_CHANNELS - 1; c >= 0; c--)
                if (bus.wr_en[c]) tbl[bus.wr_num[c*NW +: NW]] <= bus.wr_state[c*STATE_WIDTH +: STATE_WIDTH];
            for (int c = 0; c < N_CHANNELS; c++)
                rd_q[c*STATE_WIDTH +: STATE_WIDTH] <= tbl[bus.rd_num[c*NW +: NW]];
            err_q <= err_q | coll;
        end
    end
    ts_scan #(
        .N_THREADS(N_THREADS), .NW(NW), .STATE_WIDTH(STATE_WIDTH), .SCAN_WIDTH(SCAN_WIDTH)
    ) u_scan (
        .CLK(CLK), .RST(RST), .tbl_flat(tbl_flat), .ch_wr(ch_wr),
        .req(bus.scan_req), .match(bus.scan_match), .claim(bus.scan_claim),
        .busy(bus.scan_busy), .done(bus.scan_done), .hit(bus.scan_hit), .num(bus.scan_num),
        .cl_en(cl_en), .cl_num(cl_num), .cl_state(cl_state)
    );
endmodule

// File: tb/tb_thread_state_mc.sv
// tb_thread_state_mc: directed and randomized checks of thread_state_mc against a table-level reference model
module tb_thread_state_mc;
    localparam int NT = 16, NC = 4, SW = 2, NW = 4, GS = 4, NG = NT / GS;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    thread_state_mc_if #(.N_THREADS(NT), .N_CHANNELS(NC), .STATE_WIDTH(SW)) bus ();
    thread_state_mc #(.N_THREADS(NT), .N_CHANNELS(NC), .SCAN_WIDTH(GS)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;
    logic [SW-1:0] m_tbl [NT];
    logic [SW-1:0] exp_rd [NC];
    bit exp_err, exp_busy, exp_done, exp_hit, m_scan;
    int exp_num, m_sg, m_n;
    logic [SW-1:0] m_match, m_claim;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] rd_of(input int c);
        return bus.rd_state[c*SW +: SW];
    endfunction

    // reference: table as an array, writes applied highest channel first so channel 0 lands last,
    // scan as "group (start + n) mod NG examined on the n-th scan cycle"
    task automatic model_step();
        logic [SW-1:0] nt [NT];
        bit wr [NT];
        bit nd;
        int g, f;
        nd = 1'b0;
        if (RST) begin
            foreach (m_tbl[j]) m_tbl[j] = '0;
            foreach (exp_rd[c]) exp_rd[c] = '0;
            exp_err = 0; exp_busy = 0; exp_done = 0; exp_hit = 0; exp_num = 0; m_sg = 0; m_scan = 0;
            return;
        end
        for (int c = 0; c < NC; c++) exp_rd[c] = m_tbl[bus.rd_num[c*NW +: NW]];
        nt = m_tbl;
        foreach (wr[j]) wr[j] = 1'b0;
        for (int c = NC - 1; c >= 0; c--)
            if (bus.wr_en[c]) begin
                nt[bus.wr_num[c*NW +: NW]] = bus.wr_state[c*SW +: SW];
                wr[bus.wr_num[c*NW +: NW]] = 1'b1;
            end
        for (int a = 0; a < NC; a++)
            for (int b = a + 1; b < NC; b++)
                if (bus.wr_en[a] && bus.wr_en[b] && bus.wr_num[a*NW +: NW] == bus.wr_num[b*NW +: NW]) exp_err = 1;
        if (m_scan) begin
            g = (m_sg + m_n) % NG;
            f = -1;
            for (int i = GS - 1; i >= 0; i--)
                if (m_tbl[g*GS + i] == m_match && !wr[g*GS + i]) f = g*GS + i;
            if (f >= 0) begin
                nt[f] = m_claim; m_sg = (g + 1) % NG; exp_num = f; exp_hit = 1; m_scan = 0; nd = 1;
            end else begin
                m_n++;
                if (m_n == NG) begin exp_hit = 0; m_scan = 0; nd = 1; end
            end
        end else if (!exp_done && bus.scan_req) begin
            m_scan = 1; m_n = 0; m_match = bus.scan_match; m_claim = bus.scan_claim;
        end
        m_tbl = nt;
        exp_done = nd;
        exp_busy = m_scan;
    endtask

    always @(negedge CLK) if (chk_en) begin
        for (int c = 0; c < NC; c++) cmp($sformatf("rd_state[%0d]", c), rd_of(c), exp_rd[c]);
        cmp("err", bus.err, exp_err);
        cmp("scan_busy", bus.scan_busy, exp_busy);
        cmp("scan_done", bus.scan_done, exp_done);
        if (exp_done) begin
            cmp("scan_hit", bus.scan_hit, exp_hit);
            cmp("scan_num", bus.scan_num, exp_num);
        end
    end

    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle();
        bus.wr_en = '0; bus.wr_num = '0; bus.wr_state = '0; bus.rd_num = '0;
        bus.scan_req = 1'b0; bus.scan_match = '0; bus.scan_claim = '0;
    endtask

    task automatic wr(input int c, input int n, input int s);
        bus.wr_en[c] = 1'b1;
        bus.wr_num[c*NW +: NW] = NW'(n);
        bus.wr_state[c*SW +: SW] = SW'(s);
    endtask

    task automatic rd(input int c, input int n);
        bus.rd_num[c*NW +: NW] = NW'(n);
    endtask

    // k = cycle of scan_done counted from acceptance, nb = cycles with scan_busy seen
    task automatic run_scan(input int m, input int cl, output int k, output int nb, output int h, output int n);
        bus.scan_req = 1'b1; bus.scan_match = SW'(m); bus.scan_claim = SW'(cl);
        step();
        idle();
        k = 1; nb = 0;
        while (!bus.scan_done && k < 20) begin
            nb += int'(bus.scan_busy);
            step();
            k++;
        end
        if (k >= 20) cmp("scan timeout", 0, 1);
        h = int'(bus.scan_hit); n = int'(bus.scan_num);
        step();
    endtask

    initial begin
        int k, nb, h, n;
        idle();
        RST = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        RST = 1'b0;
        for (int t = 0; t < NT; t++) begin
            for (int c = 0; c < NC; c++) rd(c, t);
            step();
        end
        cmp("reset err", bus.err, 0);
        cmp("reset busy", bus.scan_busy, 0);

        idle(); wr(0, 5, 2); wr(2, 5, 3); wr(1, 9, 1); step();
        idle(); rd(0, 5); rd(1, 9); step();
        cmp("prio t5", rd_of(0), 2);
        cmp("prio t9", rd_of(1), 1);
        cmp("err set", bus.err, 1);
        idle(); step(); step();
        cmp("err sticky", bus.err, 1);

        wr(0, 3, 1); rd(3, 3); step();
        cmp("rd before write", rd_of(3), 0);
        idle(); rd(3, 3); step();
        cmp("rd after write", rd_of(3), 1);

        idle(); RST = 1'b1; step(); RST = 1'b0;
        wr(0, 5, 3); step(); idle();
        run_scan(3, 0, k, nb, h, n);
        cmp("prep num", n, 5);
        cmp("prep done cycle", k, 3);
        wr(0, 1, 1); step(); idle();
        run_scan(1, 2, k, nb, h, n);
        cmp("wrap done cycle", k, 4);
        cmp("wrap hit", h, 1);
        cmp("wrap num", n, 1);
        rd(0, 1); step();
        cmp("wrap claimed", rd_of(0), 2);
        idle();
        run_scan(3, 1, k, nb, h, n);
        cmp("miss done cycle", k, 5);
        cmp("miss busy cycles", nb, 4);
        cmp("miss hit", h, 0);
        rd(0, 1); step();
        cmp("miss unchanged", rd_of(0), 2);

        idle(); RST = 1'b1; step(); RST = 1'b0;
        wr(0, 0, 3); step(); idle();
        run_scan(3, 0, k, nb, h, n);
        cmp("cont prep num", n, 0);
        wr(0, 4, 1); wr(1, 6, 1); step(); idle();
        bus.scan_req = 1'b1; bus.scan_match = 2'd1; bus.scan_claim = 2'd2; step();
        idle(); wr(0, 4, 3); step();
        idle();
        cmp("cont done", bus.scan_done, 1);
        cmp("cont hit", bus.scan_hit, 1);
        cmp("cont num", bus.scan_num, 6);
        step();
        rd(0, 4); rd(1, 6); step();
        cmp("cont t4", rd_of(0), 3);
        cmp("cont t6", rd_of(1), 2);
        cmp("cont err", bus.err, 0);

        for (int i = 0; i < 3000; i++) begin
            idle();
            RST = $urandom_range(0, 199) == 0;
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) == 0) wr(c, $urandom_range(0, NT - 1), $urandom_range(0, 3));
                rd(c, $urandom_range(0, NT - 1));
            end
            if ($urandom_range(0, 5) == 0) begin
                bus.scan_req = 1'b1;
                bus.scan_match = SW'($urandom_range(0, 3));
                bus.scan_claim = SW'($urandom_range(0, 3));
            end
            step();
        end
        RST = 1'b0; idle(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/thread_state_mc.md
# thread_state_mc

Multi-channel thread state table: N_THREADS entries of STATE_WIDTH bits, N_CHANNELS write channels with fixed priority, one registered read port per channel, and a round-robin "find and claim" scanner that locates a thread in a requested state. It replaces the fixed 4-channel thread state store in the sha512crypt engine. It lets process_bytes, memory and the CPU side grab idle threads without polling every thread number.

## Interface
Parameters:
- N_THREADS, 16: table depth; power of 2, at least 4.
- N_THREADS_MSB, `MSB(N_THREADS-1): thread number MSB.
- N_CHANNELS, 4: number of read/write channels, 1..8.
- STATE_WIDTH, `THREAD_STATE_MSB+1: bits per entry.
- RESET_STATE, 0: value of every entry after reset.
- SCAN_WIDTH, 4: threads examined per scan cycle; power of 2 dividing N_THREADS.

Ports. One clock; reset is synchronous and active-high.
- CLK, in, 1: clock.
- RST, in, 1: synchronous active-high reset.
- wr_en, in, N_CHANNELS: per-channel write strobe.
- wr_num, in, N_CHANNELS*(N_THREADS_MSB+1): per-channel write thread number, channel i at slice i.
- wr_state, in, N_CHANNELS*STATE_WIDTH: per-channel write value.
- rd_num, in, N_CHANNELS*(N_THREADS_MSB+1): per-channel read thread number.
- rd_state, out, N_CHANNELS*STATE_WIDTH: per-channel registered read data.
- scan_req, in, 1: start a scan; accepted only when scan_busy=0.
- scan_match, in, STATE_WIDTH: state to search for, sampled at acceptance.
- scan_claim, in, STATE_WIDTH: value written to the found thread, sampled at acceptance.
- scan_busy, out, 1: scan in progress.
- scan_done, out, 1: one-cycle pulse at scan end.
- scan_hit, out, 1: valid with scan_done; 1 means a thread was found and claimed.
- scan_num, out, N_THREADS_MSB+1: found thread; held until the next scan_done.
- err, out, 1: sticky write-conflict flag.

## Operation
- Writes: the lowest-indexed channel wins when two or more channels with wr_en write the same wr_num in one cycle. Such a collision sets err. Writes of equal value also count as collisions.
- Reads: rd_state[i] gets table[rd_num[i]] as it stood before that cycle's writes.
- Scanner FSM:
  - IDLE: scan_req latches match/claim and goes to SCAN. scan_busy=1 from the next cycle.
  - SCAN: each cycle examines group g, which is threads g*SCAN_WIDTH .. g*SCAN_WIDTH+SCAN_WIDTH-1.
    - A candidate qualifies when its entry equals match and no channel writes it this cycle.
    - Lowest qualifying index wins. In that cycle the scanner writes claim to it at lowest priority, then goes to DONE with hit=1.
    - If no candidate qualifies, g increments mod N_THREADS/SCAN_WIDTH.
    - After N_THREADS/SCAN_WIDTH groups with no hit, go to DONE with hit=0.
  - DONE: scan_done=1 for one cycle, then IDLE.
- Start group: the group after the last hit group; 0 after reset.
- A scan_req that arrives while busy is dropped.
- A scanner claim never raises err. It never lands on a thread a channel writes that cycle, because that thread is disqualified.

## Timing
- Reset values: table=RESET_STATE, rd_state=RESET_STATE on all channels, scan_busy=0, scan_done=0, scan_hit=0, scan_num=0, err=0, start group=0.
- Write to read-visible: a write at cycle t shows on rd_state when the read is issued at t+1 (data appears at t+2).
- Read latency is 1 cycle.
- Scan timing, with acceptance at cycle t:
  - Groups are examined at t+1 .. t+k.
  - scan_done arrives at t+k+1, with k ≤ N_THREADS/SCAN_WIDTH.
  - Claim writes land at the end of cycle t+k, so the claimed value is readable from t+k+1.
- A new scan_req is accepted in the cycle after scan_done at the earliest.
- RST in mid-scan aborts the scan. No done pulse and no claim occur.

## Structure
- Shared header sha512.vh holds THREAD_STATE_MSB, the named thread state constants and `MSB.
- Sub-module ts_scan holds the scanner FSM, group pointer and the group compare/priority encoder. It outputs a claim write (en/num/state) to the table.
- The table, write priority mux and read registers live in thread_state_mc.

## Test plan
- Reset and reads: assert RST, then read threads 0..15 on all channels. Expect every rd_state=0, err=0 and scan_busy=0.
- Priority: at one cycle, ch0 writes thread 5=2, ch2 writes thread 5=3 and ch1 writes thread 9=1. Next cycle expect table[5]=2, table[9]=1 and err=1. err stays 1 until RST.
- Read latency: write thread 3=1 at t and read 3 at t. Expect rd_state=0 at t+1; a read issued at t+1 gives 1 at t+2.
- Scan hit with wrap:
  - Setup: N_THREADS=16, SCAN_WIDTH=4, start group=2. Only thread 1 has state 1. Scan with match=1, claim=2.
  - Expect groups 2,3,0 examined and scan_done at t+4 with scan_hit=1, scan_num=1; then table[1]=2 and start group becomes 1.
- Scan miss: no entry matches. Expect scan_busy for 4 cycles, scan_done at t+5 with scan_hit=0, and the table unchanged.
- Contention:
  - Setup: threads 4 and 6 both match. In the cycle group 1 is examined, ch0 writes thread 4.
  - Expect scan_num=6 and thread 6 claimed, thread 4 holding ch0's value, and err=0.
